bcd_to_binary_seq: RTL and testbench
====================================

// Module: bcd_to_binary_seq
// PURPOSE
//  Multi-digit packed-BCD to unsigned binary converter for RTC register decode (sec/min/hr/date/year).
//  Converts iteratively, one digit per clock, most-significant digit first: acc = acc*10 + digit.
//  Sits between the I2C read path and the timekeeping/display logic.
//  Uses valid/ready on both sides; flags illegal BCD nibbles and result overflow.
// PARAMETERS
//  DIGITS  2  number of BCD digits in bcd_in (>=1)
//  OUT_W   8  width of data_out in bits (>=4)
// PORTS
//  clk        in   1           clock; all logic on rising edge
//  rst_n      in   1           synchronous reset, active-low
//  in_valid   in   1           bcd_in valid
//  in_ready   out  1           converter idle; can accept a word
//  bcd_in     in   4*DIGITS    packed BCD; digit 0 in [3:0]
//  out_valid  out  1           result valid; held until accepted
//  out_ready  in   1           downstream accepts result
//  data_out   out  OUT_W       binary result
//  err        out  1           some nibble of the word was >9
//  ovf        out  1           value exceeded 2^OUT_W-1
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): state=IDLE. data_out=0, err=0, ovf=0, out_valid=0.
//   in_ready=1 from the first cycle after reset. Reset wins over all other inputs and aborts any conversion.
//  States:
//   IDLE: in_ready=1. On in_valid&in_ready: latch bcd_in, acc=0, digit index=DIGITS-1, err=0, ovf=0; go to CONV.
//   CONV: in_ready=0. Each edge processes the digit at the current index, then decrements the index.
//     After the digit-0 edge, go to DONE.
//   DONE: out_valid=1, in_ready=0. data_out, err and ovf are stable while in DONE.
//     On out_ready, go to IDLE (out_valid=0 next cycle).
//  Latency: out_valid rises exactly DIGITS cycles after the accept edge.
//   Throughput: one word per DIGITS+2 cycles when out_ready=1.
//   in_ready is purely state-decoded. It does not depend combinationally on out_ready.
//  Arithmetic: the internal accumulator is OUT_W+4 bits.
//   If acc*10+digit > 2^OUT_W-1 at any step, ovf is set sticky and acc is clamped to 2^OUT_W-1.
//  Illegal digit (>9): err is set sticky and the digit is treated as 0. The conversion still runs full length.
//  Output priority in DONE:
//   err=1          -> data_out=0, even if ovf=1
//   else ovf=1     -> data_out=all ones
//   else           -> data_out=acc[OUT_W-1:0]
//  in_valid asserted outside IDLE is ignored; the word is not captured.
//  out_ready outside DONE is ignored.
//  bcd_in may change freely after the accept edge.
//  A new accept is possible on the cycle after out_valid drops.
// TESTING
//  T1 DIGITS=2,OUT_W=8: bcd_in=8'h59 accepted -> 2 cycles later out_valid=1, data_out=59, err=0, ovf=0.
//  T2 Sweep 8'h00..8'h99 legal codes -> data_out equals the decimal value for all 100 codes.
//   8'h3A and 8'hA0 -> err=1, data_out=0.
//  T3 DIGITS=3,OUT_W=8:
//   12'h255 -> data_out=255, ovf=0
//   12'h256 -> ovf=1, data_out=255
//   12'h9A9 -> err=1, data_out=0
//  T4 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, data_out, err and ovf stay constant.
//   in_valid pulses during that window are ignored.
//   Releasing out_ready gives IDLE the next cycle.
//  T5 Back-to-back: in_valid held high with 8'h12 then 8'h34, out_ready=1 ->
//   results 12 then 34, spaced DIGITS+2 cycles apart.
//  T6 Reset mid-CONV: rst_n low for 1 cycle after the first digit ->
//   out_valid=0, data_out=0, err=0, ovf=0, in_ready=1 the next cycle.
//   A fresh word then converts correctly.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first,
// with sticky illegal-digit (err) and overflow (ovf) flags.
module bcd_to_binary_seq #(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      data_out,
    output logic                  err,
    output logic                  ovf
);

    localparam int AW = OUT_W + 4;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [AW-1:0] MAXV = {4'b0000, {OUT_W{1'b1}}};
    localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [4*DIGITS-1:0]  word_q;
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 err_q, ovf_q, in_ready_q, out_valid_q;
    logic [OUT_W-1:0]     data_q;

    logic [3:0]           digit;
    logic                 bad_digit;
    logic [AW-1:0]        prod;
    logic                 step_ovf;
    logic [AW-1:0]        acc_d;
    logic                 err_d, ovf_d;
    logic [OUT_W-1:0]     res_d;

    // The word is shifted left each step so the current digit is always the top nibble.
    always_comb begin
        digit     = word_q[4*DIGITS-1 -: 4];
        bad_digit = (digit > 4'd9);
        prod      = (acc_q << 3) + (acc_q << 1) + AW'(bad_digit ? 4'd0 : digit);
        step_ovf  = (prod > MAXV);
        acc_d     = step_ovf ? MAXV : prod;
        err_d     = err_q | bad_digit;
        ovf_d     = ovf_q | step_ovf;
        if (err_d)
            res_d = '0;
        else if (ovf_d)
            res_d = '1;
        else
            res_d = acc_d[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        word_q     <= bcd_in;
                        acc_q      <= '0;
                        cnt_q      <= LAST_IDX;
                        err_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc_q  <= acc_d;
                    err_q  <= err_d;
                    ovf_q  <= ovf_d;
                    word_q <= word_q << 4;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        data_q      <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized bench for bcd_to_binary_seq: a 2-digit and a 3-digit instance
// checked against a plain-arithmetic decimal model.
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv2, or2, ir2, ov2, er2, of2;
    logic [7:0]  bcd2, do2;
    logic        iv3, or3, ir3, ov3, er3, of3;
    logic [11:0] bcd3;
    logic [7:0]  do3;

    logic        sel3;
    logic        c_ir, c_ov, c_er, c_of;
    logic [7:0]  c_do;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_to_binary_seq #(.DIGITS(2), .OUT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .bcd_in(bcd2),
        .out_valid(ov2), .out_ready(or2), .data_out(do2), .err(er2), .ovf(of2));

    bcd_to_binary_seq #(.DIGITS(3), .OUT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .bcd_in(bcd3),
        .out_valid(ov3), .out_ready(or3), .data_out(do3), .err(er3), .ovf(of3));

    assign c_ir = sel3 ? ir3 : ir2;
    assign c_ov = sel3 ? ov3 : ov2;
    assign c_er = sel3 ? er3 : er2;
    assign c_of = sel3 ? of3 : of2;
    assign c_do = sel3 ? do3 : do2;

    // Reference: decimal value of the digits, illegal digits read as 0, clamp at 255.
    function automatic logic [9:0] model(input int nd, input logic [11:0] w);
        int  acc;
        int  d;
        bit  e;
        bit  o;
        acc = 0; e = 0; o = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'((w >> (4 * i)) & 12'hF);
            if (d > 9) begin e = 1; d = 0; end
            acc = acc * 10 + d;
            if (acc > 255) begin o = 1; acc = 255; end
        end
        if (e) return {1'b1, o, 8'd0};
        if (o) return {2'b01, 8'hFF};
        return {2'b00, 8'(acc)};
    endfunction

    task automatic conv(input bit s3, input logic [11:0] w, input string nm);
        logic [9:0] exp_v;
        int n;
        int nd;
        nd = s3 ? 3 : 2;
        exp_v = model(nd, w);
        sel3 = s3;
        n = 0;
        while (c_ir !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (c_ir !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready timeout: got %b want 1", nm, c_ir);
        end
        if (s3) begin bcd3 = w; iv3 = 1'b1; end
        else begin bcd2 = w[7:0]; iv2 = 1'b1; end
        @(negedge clk);
        iv2 = 1'b0; iv3 = 1'b0;
        bcd2 = 8'($urandom); bcd3 = 12'($urandom);
        n = 0;
        while (c_ov !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n !== nd) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", nm, n, nd);
        end
        vectors++;
        if ({c_er, c_of, c_do} !== exp_v) begin
            miscompares++;
            $display("FAIL %s word=%h: got err=%b ovf=%b data=%0d want err=%b ovf=%b data=%0d",
                     nm, w, c_er, c_of, c_do, exp_v[9], exp_v[8], exp_v[7:0]);
        end
        if (s3) or3 = 1'b1; else or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0; or3 = 1'b0;
        vectors++;
        if (c_ov !== 1'b0 || c_ir !== 1'b1) begin
            miscompares++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", nm, c_ov, c_ir);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ir2, ov2, er2, of2, do2} !== {4'b1000, 8'd0}) begin
            miscompares++;
            $display("FAIL reset dut2: got ir=%b ov=%b err=%b ovf=%b data=%0d want 1 0 0 0 0",
                     ir2, ov2, er2, of2, do2);
        end
        vectors++;
        if ({ir3, ov3, er3, of3, do3} !== {4'b1000, 8'd0}) begin
            miscompares++;
            $display("FAIL reset dut3: got ir=%b ov=%b err=%b ovf=%b data=%0d want 1 0 0 0 0",
                     ir3, ov3, er3, of3, do3);
        end
    endtask

    task automatic test_sweep();
        conv(0, 12'h059, "t1_59");
        for (int t = 0; t < 10; t++)
            for (int u = 0; u < 10; u++)
                conv(0, 12'((t << 4) | u), "sweep");
        conv(0, 12'h03A, "illegal_3A");
        conv(0, 12'h0A0, "illegal_A0");
        for (int k = 0; k < 20; k++)
            conv(0, 12'($urandom_range(0, 255)), "rand2");
    endtask

    task automatic test_three_digit();
        conv(1, 12'h255, "d3_255");
        conv(1, 12'h256, "d3_256");
        conv(1, 12'h9A9, "d3_9A9");
        conv(1, 12'h999, "d3_999");
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) conv(1, 12'($urandom), "rand3_any");
            else conv(1, {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))}, "rand3_legal");
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_v;
        int n;
        exp_v = model(2, 12'h087);
        sel3 = 1'b0;
        bcd2 = 8'h87; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        n = 0;
        while (ov2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int c = 0; c < 5; c++) begin
            iv2 = c[0]; bcd2 = 8'($urandom);
            @(negedge clk);
            vectors++;
            if ({ov2, ir2, er2, of2, do2} !== {2'b10, exp_v}) begin
                miscompares++;
                $display("FAIL backpressure cyc%0d: got ov=%b ir=%b err=%b ovf=%b data=%0d want 1 0 %b %b %0d",
                         c, ov2, ir2, er2, of2, do2, exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
        iv2 = 1'b0; or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;
        vectors++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure release: got ov=%b ir=%b want 0 1", ov2, ir2);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure ghost word: got ov=%b ir=%b want 0 1", ov2, ir2);
        end
    endtask

    task automatic test_back_to_back();
        int cyc_q[$];
        logic [7:0] dat_q[$];
        int n;
        sel3 = 1'b0;
        bcd2 = 8'h12; iv2 = 1'b1; or2 = 1'b1;
        @(negedge clk);
        bcd2 = 8'h34;
        for (int c = 1; c <= 10; c++) begin
            if (ov2 === 1'b1) begin cyc_q.push_back(c); dat_q.push_back(do2); end
            @(negedge clk);
        end
        iv2 = 1'b0;
        n = 0;
        while (ir2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        or2 = 1'b0;
        @(negedge clk);
        vectors++;
        if (cyc_q.size() < 2) begin
            miscompares++;
            $display("FAIL b2b results: got %0d results want at least 2", cyc_q.size());
        end else begin
            vectors++;
            if (dat_q[0] !== 8'd12 || dat_q[1] !== 8'd34) begin
                miscompares++;
                $display("FAIL b2b data: got %0d,%0d want 12,34", dat_q[0], dat_q[1]);
            end
            vectors++;
            if (cyc_q[1] - cyc_q[0] !== 4) begin
                miscompares++;
                $display("FAIL b2b spacing: got %0d want 4", cyc_q[1] - cyc_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        sel3 = 1'b0;
        bcd2 = 8'hB7; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        @(negedge clk);
        vectors++;
        if (er2 !== 1'b1 || ir2 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset precondition: got err=%b ir=%b want 1 0", er2, ir2);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({ov2, do2, er2, of2, ir2} !== {1'b0, 8'd0, 3'b001}) begin
            miscompares++;
            $display("FAIL midreset: got ov=%b data=%0d err=%b ovf=%b ir=%b want 0 0 0 0 1",
                     ov2, do2, er2, of2, ir2);
        end
        conv(0, 12'h042, "after_reset_42");
    endtask

    initial begin
        rst_n = 1'b0;
        iv2 = 1'b0; or2 = 1'b0; bcd2 = '0;
        iv3 = 1'b0; or3 = 1'b0; bcd3 = '0;
        sel3 = 1'b0;
        test_reset();
        test_sweep();
        test_three_digit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
